// File: rtl/hazard_fwd_if.sv
// Decode-side handshake between the rv32i pipeline and the hazard/forwarding unit.
// The pipeline (master) presents decode-stage register usage and the branch decision;
// the hazard unit (slave) returns stall/flush/forward controls and perf counters.
interface hazard_fwd_if #(
    parameter int ADW  = 5,
    parameter int CNTW = 16
);
    logic            validD;
    logic [ADW-1:0]  rs1D;
    logic [ADW-1:0]  rs2D;
    logic [ADW-1:0]  rdD;
    logic            regwriteD;
    logic            resultsrcD;
    logic            PCSrcE;
    logic            stallF;
    logic            stallD;
    logic            flushD;
    logic            flushE;
    logic [1:0]      fwdAE;
    logic [1:0]      fwdBE;
    logic [CNTW-1:0] stall_cnt;
    logic [CNTW-1:0] flush_cnt;

    modport master (
        output validD, rs1D, rs2D, rdD, regwriteD, resultsrcD, PCSrcE,
        input  stallF, stallD, flushD, flushE, fwdAE, fwdBE, stall_cnt, flush_cnt
    );

    modport slave (
        input  validD, rs1D, rs2D, rdD, regwriteD, resultsrcD, PCSrcE,
        output stallF, stallD, flushD, flushE, fwdAE, fwdBE, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage rv32i pipeline.
// Keeps a shadow copy of register usage through E/M/W, forwards from M (priority)
// or W, stalls on load-use (configurable length) or on any RAW when forwarding is
// disabled, lets a taken branch override every stall, and counts stalls/flushes.
module hazard_fwd_unit #(
    parameter int ADW          = 5,
    parameter int FWD_EN       = 1,
    parameter int LD_STALL_CYC = 1,
    parameter int CNTW         = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_fwd_if.slave  hz
);

    typedef struct packed {
        logic [ADW-1:0] rs1;
        logic [ADW-1:0] rs2;
        logic [ADW-1:0] rd;
        logic           rw;
        logic           ld;
    } stage_t;

    stage_t          e_q, m_q, w_q, e_d;
    logic [2:0]      scnt_q, scnt_d;
    logic [CNTW-1:0] stall_cnt_q, flush_cnt_q;

    logic match_e, match_m, lu_hit, raw_stall, stall, flush_e;
    logic [1:0] fwd_a, fwd_b;

    // Forward select for one E-stage source; newest producer (M) wins, x0 never matches.
    function automatic logic [1:0] fwd_sel(input logic [ADW-1:0] rs, input stage_t m, input stage_t w);
        if (m.rw && m.rd != '0 && m.rd == rs)
            return 2'b10;
        else if (w.rw && w.rd != '0 && w.rd == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    // Decode-stage RAW detection against E and M, plus load-use and stall/flush resolution.
    always_comb begin
        match_e   = hz.validD && e_q.rw && e_q.rd != '0 &&
                    (e_q.rd == hz.rs1D || e_q.rd == hz.rs2D);
        match_m   = hz.validD && m_q.rw && m_q.rd != '0 &&
                    (m_q.rd == hz.rs1D || m_q.rd == hz.rs2D);
        lu_hit    = match_e && e_q.ld;
        raw_stall = (FWD_EN != 0) ? (lu_hit || scnt_q != 3'd0) : (match_e || match_m);
        // A taken branch squashes whatever was stalling, so the stall is dropped.
        stall     = raw_stall && !hz.PCSrcE;
        flush_e   = raw_stall || hz.PCSrcE;
        fwd_a     = (FWD_EN != 0) ? fwd_sel(e_q.rs1, m_q, w_q) : 2'b00;
        fwd_b     = (FWD_EN != 0) ? fwd_sel(e_q.rs2, m_q, w_q) : 2'b00;
    end

    // Next E-stage shadow entry: a bubble on flush, otherwise the decode instruction.
    always_comb begin
        e_d = '0;
        if (!flush_e) begin
            e_d.rs1 = hz.rs1D;
            e_d.rs2 = hz.rs2D;
            e_d.rd  = hz.rdD;
            e_d.rw  = hz.regwriteD & hz.validD;
            e_d.ld  = hz.resultsrcD & hz.validD;
        end
    end

    // Remaining load-use bubble cycles after the detecting cycle; branch cancels them.
    always_comb begin
        scnt_d = scnt_q;
        if (hz.PCSrcE || FWD_EN == 0)
            scnt_d = 3'd0;
        else if (lu_hit)
            scnt_d = 3'(LD_STALL_CYC - 1);
        else if (scnt_q != 3'd0)
            scnt_d = scnt_q - 3'd1;
    end

    // Shadow pipeline E->M->W and the load-use countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            scnt_q <= 3'd0;
        end else begin
            e_q    <= e_d;
            m_q    <= e_q;
            w_q    <= m_q;
            scnt_q <= scnt_d;
        end
    end

    // Saturating performance counters for stall cycles and branch flushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (hz.PCSrcE && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    // Outputs are forced low while reset is held, even if PCSrcE is asserted.
    assign hz.stallF    = rst_n & stall;
    assign hz.stallD    = rst_n & stall;
    assign hz.flushD    = rst_n & hz.PCSrcE;
    assign hz.flushE    = rst_n & flush_e;
    assign hz.fwdAE     = rst_n ? fwd_a : 2'b00;
    assign hz.fwdBE     = rst_n ? fwd_b : 2'b00;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit. Three instances share one stimulus stream:
// u1 forwarding with 1-cycle load-use, u3 forwarding with 3-cycle load-use and
// 3-bit counters (to reach saturation), u0 with forwarding disabled.
module tb_hazard_fwd_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic       v, rw, ld, br;
    logic [4:0] rs1, rs2, rd;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    hazard_fwd_if #(.ADW(5), .CNTW(16)) if1 ();
    hazard_fwd_if #(.ADW(5), .CNTW(3))  if3 ();
    hazard_fwd_if #(.ADW(5), .CNTW(16)) if0 ();

    assign if1.validD = v;   assign if1.rs1D = rs1; assign if1.rs2D = rs2; assign if1.rdD = rd;
    assign if1.regwriteD = rw; assign if1.resultsrcD = ld; assign if1.PCSrcE = br;
    assign if3.validD = v;   assign if3.rs1D = rs1; assign if3.rs2D = rs2; assign if3.rdD = rd;
    assign if3.regwriteD = rw; assign if3.resultsrcD = ld; assign if3.PCSrcE = br;
    assign if0.validD = v;   assign if0.rs1D = rs1; assign if0.rs2D = rs2; assign if0.rdD = rd;
    assign if0.regwriteD = rw; assign if0.resultsrcD = ld; assign if0.PCSrcE = br;

    hazard_fwd_unit #(.ADW(5), .FWD_EN(1), .LD_STALL_CYC(1), .CNTW(16))
        u1 (.clk(clk), .rst_n(rst_n), .hz(if1.slave));
    hazard_fwd_unit #(.ADW(5), .FWD_EN(1), .LD_STALL_CYC(3), .CNTW(3))
        u3 (.clk(clk), .rst_n(rst_n), .hz(if3.slave));
    hazard_fwd_unit #(.ADW(5), .FWD_EN(0), .LD_STALL_CYC(1), .CNTW(16))
        u0 (.clk(clk), .rst_n(rst_n), .hz(if0.slave));

    // {stallF, stallD, flushE} per instance
    wire [31:0] sb1 = 32'({if1.stallF, if1.stallD, if1.flushE});
    wire [31:0] sb3 = 32'({if3.stallF, if3.stallD, if3.flushE});
    wire [31:0] sb0 = 32'({if0.stallF, if0.stallD, if0.flushE});

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_d(input logic vv, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic w, input logic l);
        v = vv; rs1 = a; rs2 = b; rd = d; rw = w; ld = l;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        br = 1'b0;
        set_d(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        // Reset state, with a branch request held during reset
        br = 1'b1;
        set_d(1, 5'd3, 5'd3, 5'd3, 1, 1);
        chk("rst_flushD", 32'(if1.flushD), 32'h0);
        chk("rst_flushE", sb1, 32'h0);
        chk("rst_cnt", 32'(if1.stall_cnt) + 32'(if1.flush_cnt), 32'h0);

        // 1: forward from M
        do_reset();
        set_d(1, 5'd1, 5'd2, 5'd5, 1, 0); step();       // add x5
        set_d(1, 5'd5, 5'd1, 5'd6, 1, 0);               // add x6,x5,x1
        chk("t1_nostall", sb1, 32'h0);
        step();
        set_d(0, 0, 0, 0, 0, 0);
        chk("t1_fwdA", 32'(if1.fwdAE), 32'h2);
        chk("t1_fwdB", 32'(if1.fwdBE), 32'h0);

        // 2a: two producers of x7, M wins
        do_reset();
        set_d(1, 5'd1, 5'd2, 5'd7, 1, 0); step();
        set_d(1, 5'd3, 5'd4, 5'd7, 1, 0); step();
        set_d(1, 5'd7, 5'd0, 5'd8, 1, 0); step();
        set_d(0, 0, 0, 0, 0, 0);
        chk("t2_Mprio", 32'(if1.fwdAE), 32'h2);
        chk("t2_x0B", 32'(if1.fwdBE), 32'h0);

        // 2b: single producer two ahead -> W
        do_reset();
        set_d(1, 5'd1, 5'd2, 5'd7, 1, 0); step();
        set_d(0, 0, 0, 0, 0, 0); step();
        set_d(1, 5'd7, 5'd7, 5'd8, 1, 0); step();
        set_d(0, 0, 0, 0, 0, 0);
        chk("t2_WA", 32'(if1.fwdAE), 32'h1);
        chk("t2_WB", 32'(if1.fwdBE), 32'h1);

        // 3: load-use, 1 cycle (u1) and 3 cycles (u3)
        do_reset();
        set_d(1, 5'd1, 5'd0, 5'd3, 1, 1); step();       // lw x3
        set_d(1, 5'd3, 5'd2, 5'd4, 1, 0);               // add x4,x3,x2 held in D
        chk("t3_u1_c1", sb1, 32'h7);
        chk("t3_u3_c1", sb3, 32'h7);
        step();
        chk("t3_u1_c2", sb1, 32'h0);
        chk("t3_u3_c2", sb3, 32'h7);
        step();
        chk("t3_u3_c3", sb3, 32'h7);
        step();
        chk("t3_u3_c4", sb3, 32'h0);
        chk("t3_u1_cnt", 32'(if1.stall_cnt), 32'd1);
        chk("t3_u3_cnt", 32'(if3.stall_cnt), 32'd3);

        // 4: x0 immunity
        do_reset();
        set_d(1, 5'd1, 5'd0, 5'd0, 1, 1); step();       // lw x0
        set_d(1, 5'd0, 5'd0, 5'd1, 1, 0);               // add x1,x0,x0
        chk("t4_nostall", sb1, 32'h0);
        step();
        set_d(0, 0, 0, 0, 0, 0);
        chk("t4_fwd", 32'({if1.fwdAE, if1.fwdBE}), 32'h0);

        // 5: branch in the same cycle as a load-use hit
        do_reset();
        set_d(1, 5'd1, 5'd0, 5'd3, 1, 1); step();
        br = 1'b1;
        set_d(1, 5'd3, 5'd2, 5'd4, 1, 0);
        chk("t5_ctl", 32'({if3.flushD, if3.flushE, if3.stallD, if3.stallF}), 32'hC);
        step();
        br = 1'b0;
        set_d(0, 0, 0, 0, 0, 0);
        chk("t5_scnt0", sb3, 32'h0);
        chk("t5_fcnt", 32'(if3.flush_cnt), 32'd1);
        chk("t5_scnt", 32'(if3.stall_cnt), 32'd0);

        // Counter saturation: 9 branch cycles
        do_reset();
        br = 1'b1;
        for (int i = 0; i < 9; i++) step();
        br = 1'b0;
        #1;
        chk("sat_u3", 32'(if3.flush_cnt), 32'd7);
        chk("sat_u1", 32'(if1.flush_cnt), 32'd9);

        // 6: no-forward mode, then reset in the second stall cycle
        do_reset();
        set_d(1, 5'd1, 5'd2, 5'd5, 1, 0); step();       // add x5
        set_d(1, 5'd5, 5'd5, 5'd6, 1, 0);               // add x6,x5,x5
        chk("t6_c1", sb0, 32'h7);
        chk("t6_fwd", 32'({if0.fwdAE, if0.fwdBE}), 32'h0);
        step();
        chk("t6_c2", sb0, 32'h7);
        chk("t6_cnt1", 32'(if0.stall_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl", 32'({if0.stallF, if0.stallD, if0.flushD, if0.flushE}), 32'h0);
        chk("t6_rst_cnt", 32'(if0.stall_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("t6_post_rst", sb0, 32'h0);
        step();
        chk("t6_restall", sb0, 32'h0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised hazard and forwarding controller for the rv32i 5-stage pipeline (F/D/E/M/W).
- Internally tracks destination and source registers through E, M and W.
- Generates stall, flush and forwarding-select signals for the decode/execute/memory datapath, replacing the tied-off flushE and external stallD/flushD.
- Adds configurable load-use stall length, a no-forwarding mode and saturating stall/flush performance counters.

Parameters:
ADW, 5, register address width
FWD_EN, 1, 1 = forward from M/W; 0 = resolve all RAW hazards by stalling
LD_STALL_CYC, 1, bubble cycles inserted on a load-use hazard (1..7)
CNTW, 16, width of each performance counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
validD  in  1  decode stage holds a real instruction
rs1D  in  ADW  source register 1 in decode
rs2D  in  ADW  source register 2 in decode
rdD  in  ADW  destination register in decode
regwriteD  in  1  decode instruction writes rd
resultsrcD  in  1  decode instruction is a load
PCSrcE  in  1  branch taken, resolved in execute
stallF  out  1  hold PC
stallD  out  1  hold decode pipeline register
flushD  out  1  clear decode pipeline register
flushE  out  1  insert bubble into execute register
fwdAE  out  2  srcA select: 00 regfile, 10 aluresultM, 01 resultW
fwdBE  out  2  srcB select, same encoding
stall_cnt  out  CNTW  saturating count of stall cycles
flush_cnt  out  CNTW  saturating count of branch flushes

Behaviour:
Reset: while rst_n=0, all shadow registers, the stall counter and both performance counters are cleared. Every output is 0.

Shadow pipeline, per clock edge:
- If flushE=1, the E-stage registers (rs1E, rs2E, rdE, rwE, ldE) load 0.
- Otherwise they load rs1D, rs2D, rdD, regwriteD&validD, resultsrcD&validD.
- M <= E and W <= M on every edge.

Register x0: address 0 never matches for hazard or forwarding purposes.

Forwarding (FWD_EN=1), combinational from registered state, zero latency:
- fwdAE=10 if rwM && rdM!=0 && rdM==rs1E.
- Else fwdAE=01 if rwW && rdW!=0 && rdW==rs1E.
- Else fwdAE=00.
- fwdBE follows the same rules using rs2E.
- M priority over W is mandatory.

Load-use (FWD_EN=1):
- Hit condition: validD && ldE && rwE && rdE!=0 && (rdE==rs1D || rdE==rs2D).
- On a hit, stallF=stallD=flushE=1 that cycle, and scnt loads LD_STALL_CYC-1.
- While scnt>0: stallF=stallD=flushE=1 and scnt decrements each cycle.

No-forward mode (FWD_EN=0):
- fwdAE=fwdBE=00 always.
- Stall (stallF=stallD=flushE=1) whenever validD and rs1D or rs2D (nonzero) matches rdE with rwE, or rdM with rwM.
- W-stage matches are covered by the reg_file write-before-read bypass.
- scnt is unused.

Branch:
- PCSrcE=1 forces flushD=1, flushE=1, stallF=stallD=0 and clears scnt. Branch overrides any stall in the same cycle.

Counters:
- stall_cnt increments on each cycle with stallD=1.
- flush_cnt increments on each cycle with PCSrcE=1.
- Both saturate at all-ones and never wrap.

Concurrency and reset: simultaneous load-use and branch take the branch response only. Reset asserted mid-stall aborts the stall immediately; the first cycle after reset release produces no stall.

Test Plan:
1. Forward from M: lw-free sequence add x5 then add x6,x5,x1, FWD_EN=1 -> in the consumer's E cycle fwdAE=10, fwdBE=00, no stall.
2. Forward from W with M priority: write x7 in two consecutive older instructions, consumer reads x7 -> fwdAE=10 (newer); with a single producer two instructions ahead -> fwdAE=01.
3. Load-use, LD_STALL_CYC=1: lw x3 then add x4,x3,x2 -> exactly 1 cycle of stallF=stallD=flushE=1, stall_cnt=1; LD_STALL_CYC=3 -> 3 stall cycles, stall_cnt=3.
4. x0 immunity: lw x0 followed by add x1,x0,x0 -> no stall, fwdAE=fwdBE=00.
5. Branch over stall: load-use hit in the same cycle as PCSrcE=1 -> flushD=flushE=1, stallD=0, flush_cnt=1, scnt=0 next cycle.
6. FWD_EN=0 plus reset: add x5 then add x6,x5,x5 -> 2 stall cycles, fwd=00; assert rst_n=0 during the second stall cycle -> all outputs 0 immediately, counters 0.
